// File: rtl/aib_align_pkg.sv
`default_nettype none
// ==== aib_align_pkg : shared types, widths and helpers for the AIB RX word aligner (rev 1.0) ====
package aib_align_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   localparam int DATA_W    = 80;
   localparam int HALF_W    = 40;
   localparam int HI_MKR    = 79;
   localparam int LO_MKR    = 39;
   localparam int PAYLOAD_W = 78;

   function automatic logic [PAYLOAD_W-1:0] strip_markers(input logic [DATA_W-1:0] w);
      return {w[HI_MKR-1:HALF_W], w[LO_MKR-1:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/aib_marker_detect.sv
`default_nettype none
// ==== aib_marker_detect : marker match and word rebuild for both half-word offsets (rev 1.0) ====
module aib_marker_detect
   import aib_align_pkg::*;
(
   input  logic [DATA_W-1:0] rx_data_i,
   input  logic [HALF_W-1:0] prev_hi_i,
   output logic              match0_o,
   output logic              match1_o,
   output logic [DATA_W-1:0] word0_o,
   output logic [DATA_W-1:0] word1_o
);

   // 00 and 11 marker pairs fall out as matching neither offset.
   assign match0_o = rx_data_i[HI_MKR] & ~rx_data_i[LO_MKR];
   assign match1_o = rx_data_i[LO_MKR] & ~rx_data_i[HI_MKR];

   assign word0_o  = rx_data_i;
   // Offset 1: the high half arrives in the low lane, the low half came one word earlier.
   assign word1_o  = {rx_data_i[HALF_W-1:0], prev_hi_i};

endmodule
`default_nettype wire

// File: rtl/aib_rx_word_aligner.sv
`default_nettype none
// ==== aib_rx_word_aligner : marker-based word alignment with HUNT/VERIFY/LOCKED tracking (rev 1.0) ====
module aib_rx_word_aligner
   import aib_align_pkg::*;
#(
   parameter int LOCK_CNT = 8,
   parameter int LOSS_CNT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    rx_data,
   input  logic                 rx_en,
   input  logic                 relock,
   output logic [PAYLOAD_W-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_mkr_err,
   output logic                 o_locked,
   output logic                 o_offset,
   output logic [15:0]          o_err_cnt
);

   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(LOSS_CNT + 1);

   state_e               state_q, state_d;
   logic [GOOD_W-1:0]    good_q, good_d;
   logic [BAD_W-1:0]     bad_q, bad_d;
   logic [HALF_W-1:0]    prev_hi_q;
   logic                 offset_q, offset_d;
   logic [PAYLOAD_W-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 mkr_err_q, mkr_err_d;
   logic                 locked_q;
   logic [15:0]          err_cnt_q, err_cnt_d;

   logic                 w_match0, w_match1, w_sel_match;
   logic [DATA_W-1:0]    w_word0, w_word1, w_sel_word;

   aib_marker_detect u_detect (
      .rx_data_i (rx_data),
      .prev_hi_i (prev_hi_q),
      .match0_o  (w_match0),
      .match1_o  (w_match1),
      .word0_o   (w_word0),
      .word1_o   (w_word1)
   );

   always_comb begin
      w_sel_match = offset_q ? w_match1 : w_match0;
      w_sel_word  = offset_q ? w_word1  : w_word0;
      state_d     = state_q;
      good_d      = good_q;
      bad_d       = bad_q;
      offset_d    = offset_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      mkr_err_d   = 1'b0;
      err_cnt_d   = err_cnt_q;
      if (rx_en) begin
         case (state_q)
            HUNT: begin
               if (w_match0 | w_match1) begin
                  offset_d = w_match1;
                  good_d   = GOOD_W'(1);
                  state_d  = VERIFY;
               end
            end
            VERIFY: begin
               if (!w_sel_match) begin
                  state_d = HUNT;
                  good_d  = '0;
               end else if (int'(good_q) + 1 >= LOCK_CNT) begin
                  state_d = LOCKED;
                  good_d  = '0;
               end else begin
                  good_d  = good_q + GOOD_W'(1);
               end
            end
            LOCKED: begin
               valid_d = 1'b1;
               data_d  = strip_markers(w_sel_word);
               if (w_sel_match) begin
                  bad_d = '0;
               end else begin
                  mkr_err_d = 1'b1;
                  if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                  // The word that exhausts the budget is still delivered, flagged.
                  if (int'(bad_q) + 1 >= LOSS_CNT) begin
                     state_d = HUNT;
                     bad_d   = '0;
                  end else begin
                     bad_d   = bad_q + BAD_W'(1);
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
      if (relock) begin
         state_d = HUNT;
         good_d  = '0;
         bad_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HUNT;
         good_q    <= '0;
         bad_q     <= '0;
         prev_hi_q <= '0;
         offset_q  <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         mkr_err_q <= 1'b0;
         locked_q  <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
         offset_q  <= offset_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         mkr_err_q <= mkr_err_d;
         locked_q  <= (state_d == LOCKED);
         err_cnt_q <= err_cnt_d;
         if (rx_en) prev_hi_q <= rx_data[DATA_W-1:HALF_W];
      end
   end

   assign o_data    = data_q;
   assign o_valid   = valid_q;
   assign o_mkr_err = mkr_err_q;
   assign o_locked  = locked_q;
   assign o_offset  = offset_q;
   assign o_err_cnt = err_cnt_q;

endmodule
`default_nettype wire
